// File: rtl/vote_result_reader_pkg.sv
// Shared types and constants for the vote result readout path.
// Holds the FSM state enum, the frame constants and the winner encodings.
package vote_result_reader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CAPTURE,
    COMPARE,
    SEND,
    DONE
  } state_t;

  localparam logic [7:0]  HDR_DEFAULT = 8'hA5;
  localparam int unsigned N_BYTES     = 14;

  localparam logic [1:0] WIN_NONE = 2'd0;
  localparam logic [1:0] WIN_C1   = 2'd1;
  localparam logic [1:0] WIN_C2   = 2'd2;
  localparam logic [1:0] WIN_C3   = 2'd3;

endpackage

// File: rtl/vote_max3.sv
// Combinational 3-way unsigned max comparator.
// Reports the unique winner, a shared nonzero maximum (tie), and the all-zero case.
module vote_max3
  import vote_result_reader_pkg::*;
(
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  input  logic [31:0] i_c,
  output logic [1:0]  o_winner,
  output logic        o_tie,
  output logic        o_all_zero
);

  logic [31:0] max_v;
  logic        eq_a, eq_b, eq_c;
  logic [1:0]  n_eq;

  always_comb begin
    max_v = i_a;
    if (i_b > max_v) max_v = i_b;
    if (i_c > max_v) max_v = i_c;

    eq_a = (i_a == max_v);
    eq_b = (i_b == max_v);
    eq_c = (i_c == max_v);
    n_eq = {1'b0, eq_a} + {1'b0, eq_b} + {1'b0, eq_c};

    o_all_zero = (max_v == '0);
    o_tie      = !o_all_zero && (n_eq >= 2'd2);

    o_winner = WIN_NONE;
    if (!o_all_zero && (n_eq == 2'd1)) begin
      if (eq_a)      o_winner = WIN_C1;
      else if (eq_b) o_winner = WIN_C2;
      else           o_winner = WIN_C3;
    end
  end

endmodule

// File: rtl/vote_result_reader.sv
// Captures three vote tallies on a rising i_voting_over, picks the winner,
// and streams a 14-byte ready/valid frame: header, status, then counts MSB first.
module vote_result_reader #(
  parameter logic [7:0]  HDR     = vote_result_reader_pkg::HDR_DEFAULT,
  parameter int unsigned N_BYTES = vote_result_reader_pkg::N_BYTES
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_voting_over,
  input  logic [31:0] i_count1,
  input  logic [31:0] i_count2,
  input  logic [31:0] i_count3,
  input  logic        i_ready,
  output logic [7:0]  o_data,
  output logic        o_valid,
  output logic [1:0]  o_winner,
  output logic        o_tie,
  output logic        o_busy,
  output logic        o_done
);

  import vote_result_reader_pkg::*;

  localparam logic [3:0] LAST_IDX = 4'(N_BYTES - 1);

  state_t      state_q, state_d;
  logic        prev_q, prev_d;
  logic [3:0]  idx_q, idx_d;
  logic [31:0] cnt1_q, cnt1_d, cnt2_q, cnt2_d, cnt3_q, cnt3_d;
  logic [1:0]  winner_q, winner_d;
  logic        tie_q, tie_d;
  logic        nozero_q, nozero_d;
  logic [7:0]  data_q, data_d;
  logic        valid_q, valid_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  logic        rise;
  logic [1:0]  cmp_winner;
  logic        cmp_tie;
  logic        cmp_all_zero;

  vote_max3 u_max3 (
    .i_a        (cnt1_q),
    .i_b        (cnt2_q),
    .i_c        (cnt3_q),
    .o_winner   (cmp_winner),
    .o_tie      (cmp_tie),
    .o_all_zero (cmp_all_zero)
  );

  function automatic logic [7:0] frame_byte(
    input logic [3:0]  i,
    input logic [7:0]  hdr,
    input logic [7:0]  status,
    input logic [31:0] a,
    input logic [31:0] b,
    input logic [31:0] c
  );
    case (i)
      4'd0:    return hdr;
      4'd1:    return status;
      4'd2:    return a[31:24];
      4'd3:    return a[23:16];
      4'd4:    return a[15:8];
      4'd5:    return a[7:0];
      4'd6:    return b[31:24];
      4'd7:    return b[23:16];
      4'd8:    return b[15:8];
      4'd9:    return b[7:0];
      4'd10:   return c[31:24];
      4'd11:   return c[23:16];
      4'd12:   return c[15:8];
      4'd13:   return c[7:0];
      default: return 8'h00;
    endcase
  endfunction

  always_comb begin
    rise     = i_voting_over & ~prev_q;
    prev_d   = i_voting_over;
    state_d  = state_q;
    idx_d    = idx_q;
    cnt1_d   = cnt1_q;
    cnt2_d   = cnt2_q;
    cnt3_d   = cnt3_q;
    winner_d = winner_q;
    tie_d    = tie_q;
    nozero_d = nozero_q;
    data_d   = data_q;
    valid_d  = valid_q;
    done_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (rise) state_d = CAPTURE;
      end
      CAPTURE: begin
        cnt1_d  = i_count1;
        cnt2_d  = i_count2;
        cnt3_d  = i_count3;
        state_d = COMPARE;
      end
      COMPARE: begin
        winner_d = cmp_winner;
        tie_d    = cmp_tie;
        nozero_d = cmp_all_zero;
        idx_d    = '0;
        data_d   = HDR;
        valid_d  = 1'b1;
        state_d  = SEND;
      end
      SEND: begin
        // Next byte is preloaded on each transfer so o_data only moves on a handshake.
        if (valid_q && i_ready) begin
          if (idx_q == LAST_IDX) begin
            valid_d = 1'b0;
            data_d  = '0;
            idx_d   = '0;
            done_d  = 1'b1;
            state_d = DONE;
          end else begin
            idx_d  = idx_q + 4'd1;
            data_d = frame_byte(idx_q + 4'd1, HDR, {tie_q, nozero_q, 4'b0000, winner_q},
                                cnt1_q, cnt2_q, cnt3_q);
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      prev_q   <= 1'b0;
      idx_q    <= '0;
      cnt1_q   <= '0;
      cnt2_q   <= '0;
      cnt3_q   <= '0;
      winner_q <= WIN_NONE;
      tie_q    <= 1'b0;
      nozero_q <= 1'b0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      prev_q   <= prev_d;
      idx_q    <= idx_d;
      cnt1_q   <= cnt1_d;
      cnt2_q   <= cnt2_d;
      cnt3_q   <= cnt3_d;
      winner_q <= winner_d;
      tie_q    <= tie_d;
      nozero_q <= nozero_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign o_data   = data_q;
  assign o_valid  = valid_q;
  assign o_winner = winner_q;
  assign o_tie    = tie_q;
  assign o_busy   = busy_q;
  assign o_done   = done_q;

endmodule
